// File: rtl/vram_line_fetcher_pkg.sv
// Shared types and helpers for the VRAM line fetcher: FSM state encoding and a
// constant-foldable ceil(log2) used for counter and pointer widths.
package vram_line_fetcher_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StDrain = 2'd2
   } state_e;

   // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 0) ? value - 1 : 0;
      r = 0;
      while (v > 0) begin
         v = v >> 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/vram_line_fetcher_sync_fifo.sv
// First-word-fall-through synchronous FIFO; depth must be a power of two >= 2.
module vram_line_fetcher_sync_fifo
   import vram_line_fetcher_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned PtrW = clog2(FIFO_DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [CntW-1:0]       count,
   output logic                  empty,
   output logic                  full
);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  do_push;
   logic                  do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CntW'(FIFO_DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(FIFO_DEPTH));

endmodule

// File: rtl/vram_line_fetcher.sv
// Streams LINE_LENGTH consecutive VRAM words per start pulse to a valid/ready consumer,
// issuing reads only when buffer space is guaranteed for their return.
module vram_line_fetcher
   import vram_line_fetcher_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 10,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned LINE_LENGTH   = 80,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
   output logic                     mem_read_enable,
   input  logic [DATA_WIDTH-1:0]    mem_read_data,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int unsigned IssueW = clog2(LINE_LENGTH + 1);
   localparam int unsigned CntW   = clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CredW  = CntW + 1;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] base_q, base_d;
   logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [IssueW-1:0]        issued_q, issued_d;
   logic                     rd_en_q, rd_en_d;
   logic                     inflight_q, inflight_d;
   logic [CntW-1:0]          fifo_count;
   logic                     fifo_empty;
   logic                     fifo_full;
   logic                     pop;
   logic                     issue;
   logic [CredW-1:0]         credits_used;

   // A read holds a credit from the cycle it is presented to memory until its data is buffered.
   assign credits_used = CredW'(fifo_count) + CredW'(rd_en_q) + CredW'(inflight_q);
   assign pop          = !fifo_empty && out_ready;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      issued_d   = issued_q;
      rd_addr_d  = rd_addr_q;
      rd_en_d    = 1'b0;
      inflight_d = rd_en_q;
      issue      = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StFetch;
               base_d   = base_addr;
               issued_d = '0;
            end
         end
         StFetch: begin
            issue = (issued_q < IssueW'(LINE_LENGTH)) && (credits_used < CredW'(FIFO_DEPTH));
            if (issue) begin
               rd_en_d   = 1'b1;
               rd_addr_d = base_q + ADDRESS_WIDTH'(issued_q);
               issued_d  = issued_q + 1'b1;
               if (issued_d == IssueW'(LINE_LENGTH)) state_d = StDrain;
            end
         end
         StDrain: begin
            if (fifo_empty && !rd_en_q && !inflight_q) begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         base_q     <= '0;
         rd_addr_q  <= '0;
         issued_q   <= '0;
         rd_en_q    <= 1'b0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         rd_addr_q  <= rd_addr_d;
         issued_q   <= issued_d;
         rd_en_q    <= rd_en_d;
         inflight_q <= inflight_d;
      end
   end

   vram_line_fetcher_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inflight_q),
      .pop   (pop),
      .wdata (mem_read_data),
      .rdata (out_data),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign busy            = (state_q != StIdle);
   assign mem_read_addr   = rd_addr_q;
   assign mem_read_enable = rd_en_q;
   assign out_valid       = !fifo_empty;

   credit_bound_a: assert property (@(posedge clk) disable iff (reset)
      credits_used <= CredW'(FIFO_DEPTH));
   no_overflow_a: assert property (@(posedge clk) disable iff (reset)
      inflight_q |-> (!fifo_full || pop));

endmodule

// File: tb/tb_vram_line_fetcher.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks the stream.
module tb_vram_line_fetcher;

   localparam int AW = 10;
   localparam int DW = 8;
   localparam int LL = 80;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_read_addr;
   logic          mem_read_enable;
   logic [DW-1:0] mem_read_data = '0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          ready_man;
   logic          ready_rnd = 1'b1;
   logic          rand_en;

   logic [DW-1:0] mem [1 << AW];
   logic [DW-1:0] exp_q [$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int tot_pops = 0;
   int done_cnt = 0;
   int line_base = 0;
   int line_seq  = 0;
   int seen_seq  = 0;
   int accept_cyc = 0;
   int first_hs_cyc = 0;
   int last_hs_cyc  = 0;

   assign out_ready = rand_en ? ready_rnd : ready_man;

   vram_line_fetcher #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .LINE_LENGTH   (LL),
      .FIFO_DEPTH    (FD)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .base_addr       (base_addr),
      .busy            (busy),
      .done            (done),
      .mem_read_addr   (mem_read_addr),
      .mem_read_enable (mem_read_enable),
      .mem_read_data   (mem_read_data),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Video memory model: one-cycle synchronous read.
   always @(posedge clk) if (mem_read_enable) mem_read_data <= mem[mem_read_addr];

   initial forever begin
      @(posedge clk);
      #1;
      ready_rnd = 1'($urandom_range(0, 1));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every presented word must equal the queue head, whether or not it is taken.
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got 0x%0h expected no word", out_data);
            end else begin
               check("out_data", 32'(out_data), 32'(exp_q[0]));
               if (seen_seq != line_seq) begin
                  check("first_latency", cyc - accept_cyc, 3);
                  seen_seq = line_seq;
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  if (tot_pops == line_base) first_hs_cyc = cyc;
                  tot_pops++;
                  last_hs_cyc = cyc;
               end
            end
         end
         if (done) begin
            done_cnt++;
            check("done_after_last_word", cyc - last_hs_cyc, 1);
            check("done_queue_empty", exp_q.size(), 0);
         end
      end
   end

   // Called at posedge+1; start is taken at the next edge.
   task automatic start_line(input logic [AW-1:0] base);
      logic [AW-1:0] a;
      for (int i = 0; i < LL; i++) begin
         a = base + AW'(i);
         exp_q.push_back(a[DW-1:0]);
      end
      line_base = tot_pops;
      start     = 1'b1;
      base_addr = base;
      @(posedge clk);
      #1;
      start      = 1'b0;
      accept_cyc = cyc;
      line_seq++;
      check("busy_after_start", busy, 1);
   endtask

   task automatic pulse_start(input logic [AW-1:0] base);
      start     = 1'b1;
      base_addr = base;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n0;
      int k;
      n0 = done_cnt;
      k  = 0;
      while (done_cnt == n0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (done_cnt == n0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
      end
   endtask

   task automatic wait_pops(input int n, input int budget);
      int k;
      k = 0;
      while ((tot_pops - line_base) < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      check("pop_wait", tot_pops - line_base, n);
   endtask

   initial begin
      int n0;
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      ready_man = 1'b1;
      rand_en   = 1'b0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = i[DW-1:0];
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", mem_read_enable, 0);
      check("rst_rd_addr", 32'(mem_read_addr), 0);
      check("rst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic line at full rate.
      start_line(10'h010);
      wait_done(400);
      check("t1_words", tot_pops - line_base, LL);
      check("t1_rate", last_hs_cyc - first_hs_cyc, LL - 1);

      // Backpressure mid-line.
      start_line(10'h020);
      wait_pops(30, 200);
      ready_man = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("t2_reads_stopped", mem_read_enable, 0);
      check("t2_valid_held", out_valid, 1);
      check("t2_no_pop_in_stall", tot_pops - line_base, 30);
      @(posedge clk);
      #1;
      ready_man = 1'b1;
      wait_done(400);
      check("t2_words", tot_pops - line_base, LL);

      // Address wrap at the top of memory.
      start_line(10'h3F0);
      wait_done(400);
      check("t3_words", tot_pops - line_base, LL);

      // Start pulses while busy are ignored.
      n0 = done_cnt;
      start_line(10'h080);
      repeat (5) @(posedge clk);
      #1;
      pulse_start(10'h200);
      wait_pops(78, 200);
      pulse_start(10'h300);
      wait_done(400);
      check("t4_words", tot_pops - line_base, LL);
      repeat (6) @(posedge clk);
      #1;
      check("t4_single_done", done_cnt - n0, 1);
      check("t4_idle", busy, 0);
      check("t4_no_extra_line", out_valid, 0);

      // Reset mid-line aborts without done, then a fresh line works.
      start_line(10'h150);
      wait_pops(20, 200);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("t5_busy", busy, 0);
      check("t5_out_valid", out_valid, 0);
      check("t5_rd_en", mem_read_enable, 0);
      check("t5_rd_addr", 32'(mem_read_addr), 0);
      check("t5_done", done, 0);
      n0 = done_cnt;
      repeat (10) @(posedge clk);
      #1;
      check("t5_no_done", done_cnt, n0);
      start_line(10'h150);
      wait_done(400);
      check("t5_words", tot_pops - line_base, LL);

      // Random backpressure with back-to-back lines.
      rand_en = 1'b1;
      start_line(10'h100);
      wait_done(1500);
      check("t6_words_a", tot_pops - line_base, LL);
      start_line(10'h2C0);
      wait_done(1500);
      check("t6_words_b", tot_pops - line_base, LL);
      start_line(10'h3E8);
      wait_done(1500);
      check("t6_words_c", tot_pops - line_base, LL);
      rand_en = 1'b0;

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish before 500000 time units");
      $fatal(1);
   end

endmodule
